add_resp_checker: RTL and testbench
===================================

// Module: add_resp_checker
// PURPOSE
//  Response-side checker for the 5-bit adder datapath under test. It captures each
//  operand set (a, b, cin) and computes the expected {cout, sum}. It queues that
//  expectation in an in-order FIFO and compares it with the result returned by the
//  adder some cycles later.
//  It sits opposite the stimulus driver: the driver pushes operands, this block
//  consumes results and reports pass/fail counts for a run of N_VEC vectors.
// PARAMETERS
//  WIDTH  5   operand / sum width in bits
//  DEPTH  4   expectation FIFO entries (power of 2); bounds max adder latency
//  CNT_W  8   width of pass/error counters
//  N_VEC  16  vectors per run; must be <= 2**CNT_W-1
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst        in   1        synchronous reset, active-high
//  start      in   1        1-cycle pulse: begin a run (accepted in IDLE or DONE only)
//  in_valid   in   1        operand set valid this cycle
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B
//  in_cin     in   1        carry-in
//  res_valid  in   1        adder result valid this cycle
//  res_sum    in   WIDTH    adder sum
//  res_cout   in   1        adder carry-out
//  busy       out  1        high in RUN or DRAIN
//  done       out  1        high in DONE
//  mismatch   out  1        1-cycle pulse: last compared result was wrong
//  pass_cnt   out  CNT_W    results that matched
//  err_cnt    out  CNT_W    results that mismatched
//  ovf_err    out  1        sticky: push attempted while FIFO full
//  unf_err    out  1        sticky: result arrived with FIFO empty
// BEHAVIOUR
//  - rst (any state, any cycle): state=IDLE, FIFO empty, all outputs 0.
//  - Expected value: {exp_cout, exp_sum} = in_a + in_b + in_cin, computed WIDTH+1 wide
//    (unsigned). It is pushed into the FIFO in the same cycle as in_valid.
//  - FSM:
//    IDLE  -start->                  RUN   (counters, flags and FIFO cleared on entry)
//    RUN   -N_VEC pushes accepted->  DRAIN
//    DRAIN -pass_cnt+err_cnt==N_VEC-> DONE
//    DONE  -start->                  RUN   (clears as above)
//    start in RUN or DRAIN is ignored.
//  - Push: only in RUN when in_valid. An overflow push (FIFO full, no pop this
//    cycle) is dropped, sets ovf_err, and does not count toward N_VEC.
//  - Pop/compare: in RUN or DRAIN when res_valid and FIFO non-empty. The result
//    matches only if {res_cout, res_sum} equals the FIFO head.
//    On the next cycle: pass_cnt+1, or err_cnt+1 with mismatch=1. Compare latency
//    is 1 cycle.
//  - res_valid with FIFO empty: sets unf_err. No counter changes and no mismatch.
//  - Simultaneous push and pop when full: both occur and occupancy is unchanged.
//    This is not an overflow.
//  - Simultaneous push and pop when empty: the result is checked against the
//    previous head only. With an empty FIFO it is an underflow (no bypass).
//  - IDLE and DONE ignore in_valid and res_valid. DRAIN ignores in_valid with no
//    flag.
//  - Counters saturate at 2**CNT_W-1. FIFO pointers wrap modulo DEPTH; full and
//    empty are decided from an extra pointer bit.
//  - mismatch is 0 in every cycle that is not the cycle after a failed compare.
// TESTING
//  1 rst high 2 cycles mid-RUN -> next cycle IDLE, pass_cnt=err_cnt=0, busy=0, flags 0.
//  2 start; a=5'b10011, b=5'b00011, cin=0; result 2 cycles later sum=5'b10110,
//    cout=0 -> pass_cnt=1, mismatch stays 0.
//  3 a=5'b11111, b=5'b00001, cin=1; result sum=5'b00001, cout=0 ->
//    err_cnt=1, mismatch pulses 1 cycle (expected cout=1).
//  4 5 back-to-back in_valid, no results, DEPTH=4 -> 5th push dropped,
//    ovf_err=1, FIFO holds 4.
//  5 res_valid after reset+start with no push -> unf_err=1, counters 0.
//  6 16 vectors, adder latency 3, all correct -> RUN->DRAIN after 16th push,
//    DONE when pass_cnt=16; start again -> RUN, counters 0.

Source files
------------

// File: rtl/add_resp_checker.sv
// Response checker for the adder datapath: queues expected {cout, sum} per operand set
// and scores returned results in order, reporting pass/error counts over a run.
//
// state | meaning
// IDLE  | waiting for start, inputs ignored
// RUN   | accepting operands (push) and scoring results (pop)
// DRAIN | all operands taken, scoring remaining results
// DONE  | every vector scored, waiting for start
module add_resp_checker #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  parameter int N_VEC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_sum,
  input  logic             res_cout,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             ovf_err,
  output logic             unf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_PUSH = CNT_W'(N_VEC - 1);
  localparam logic [CNT_W:0]   N_VEC_T   = (CNT_W + 1)'(N_VEC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   fifo_mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [CNT_W-1:0] push_cnt;

  logic             active;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             ovf;
  logic             unf;
  logic             res_ok;
  logic [WIDTH:0]   exp_val;
  logic [CNT_W:0]   cmp_total;

  assign active    = (state == RUN) || (state == DRAIN);
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = active && res_valid && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still legal.
  assign push      = (state == RUN) && in_valid && (!full || pop);
  assign ovf       = (state == RUN) && in_valid && full && !pop;
  assign unf       = active && res_valid && empty;
  assign exp_val   = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
  assign res_ok    = ({res_cout, res_sum} == fifo_mem[rd_ptr[AW-1:0]]);
  assign cmp_total = {1'b0, pass_cnt} + {1'b0, err_cnt};

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= exp_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      pass_cnt <= '0;
      err_cnt  <= '0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      push_cnt <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass_cnt <= '0;
            err_cnt  <= '0;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            push_cnt <= '0;
          end
        end
        RUN: begin
          if (push && (push_cnt == LAST_PUSH)) state <= DRAIN;
        end
        DRAIN: begin
          if (cmp_total == N_VEC_T) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        wr_ptr   <= wr_ptr + (AW + 1)'(1);
        push_cnt <= push_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
        if (res_ok) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          mismatch <= 1'b1;
        end
      end
      if (ovf) ovf_err <= 1'b1;
      if (unf) unf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_add_resp_checker.sv
// Directed bench for add_resp_checker: table of operand/result vectors plus
// hand-written sequences for overflow, underflow, full/empty corner cases and a full run.
module tb_add_resp_checker;

  localparam int WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int N_VEC = 16;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_cin, res_valid, res_cout;
  logic [WIDTH-1:0] in_a, in_b, res_sum;
  logic             busy, done, mismatch, ovf_err, unf_err;
  logic [CNT_W-1:0] pass_cnt, err_cnt;

  int n_vec = 0;
  int n_bad = 0;

  add_resp_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .N_VEC(N_VEC)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout),
    .busy(busy), .done(done), .mismatch(mismatch), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a, b;
    logic       cin;
    logic [4:0] sum;
    logic       cout;
    logic       ok;
  } vec_t;

  vec_t tbl[10];
  logic [4:0] va[5], vb[5];
  logic       vc[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; res_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  function automatic logic [5:0] ref_add(input logic [4:0] a, input logic [4:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {5'b0, c};
  endfunction

  task automatic set_push(input int k);
    in_valid = 1'b1; in_a = va[k]; in_b = vb[k]; in_cin = vc[k];
  endtask

  task automatic set_res(input int k);
    res_valid = 1'b1; {res_cout, res_sum} = ref_add(va[k], vb[k], vc[k]);
  endtask

  initial begin
    int exp_pass, exp_err;
    in_a = '0; in_b = '0; in_cin = 1'b0; res_sum = '0; res_cout = 1'b0;
    //              a         b         cin   sum       cout  ok
    tbl[0] = '{5'b10011, 5'b00011, 1'b0, 5'b10110, 1'b0, 1'b1};
    tbl[1] = '{5'b11111, 5'b00001, 1'b1, 5'b00001, 1'b0, 1'b0};
    tbl[2] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b1};
    tbl[3] = '{5'b11111, 5'b11111, 1'b1, 5'b11111, 1'b1, 1'b1};
    tbl[4] = '{5'b10000, 5'b10000, 1'b0, 5'b00000, 1'b1, 1'b1};
    tbl[5] = '{5'b01010, 5'b00101, 1'b1, 5'b10000, 1'b0, 1'b1};
    tbl[6] = '{5'b01010, 5'b00101, 1'b0, 5'b01110, 1'b0, 1'b0};
    tbl[7] = '{5'b11111, 5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0};
    tbl[8] = '{5'b00111, 5'b11000, 1'b1, 5'b00000, 1'b1, 1'b1};
    tbl[9] = '{5'b11110, 5'b00001, 1'b0, 5'b11111, 1'b0, 1'b1};
    va = '{5'd3, 5'd31, 5'd17, 5'd8, 5'd22};
    vb = '{5'd9, 5'd1, 5'd20, 5'd8, 5'd30};
    vc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state, and IDLE ignoring results
    do_reset();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_pass", pass_cnt, 0); chk("rst_err", err_cnt, 0);
    res_valid = 1'b1; cyc(); res_valid = 1'b0;
    chk("idle_unf_ignored", unf_err, 0);

    // Table-driven: push, result two cycles later, compare one cycle after result
    do_start();
    chk("start_busy", busy, 1);
    exp_pass = 0; exp_err = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = tbl[i].a; in_b = tbl[i].b; in_cin = tbl[i].cin;
      cyc(); in_valid = 1'b0;
      cyc();
      res_valid = 1'b1; res_sum = tbl[i].sum; res_cout = tbl[i].cout;
      cyc(); res_valid = 1'b0;
      if (tbl[i].ok) exp_pass++; else exp_err++;
      chk($sformatf("tbl%0d_pass", i), pass_cnt, exp_pass);
      chk($sformatf("tbl%0d_err", i), err_cnt, exp_err);
      chk($sformatf("tbl%0d_mismatch", i), mismatch, !tbl[i].ok);
      cyc();
      chk($sformatf("tbl%0d_mismatch_clr", i), mismatch, 0);
    end

    // Reset held 2 cycles mid-run
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    chk("midrst_busy", busy, 0); chk("midrst_pass", pass_cnt, 0);
    chk("midrst_err", err_cnt, 0); chk("midrst_ovf", ovf_err, 0); chk("midrst_unf", unf_err, 0);

    // Overflow: 5 back-to-back pushes, 5th dropped; FIFO then yields exactly 4
    do_start();
    for (int k = 0; k < 5; k++) begin
      set_push(k); cyc();
      if (k == 3) chk("ovf_after4", ovf_err, 0);
    end
    in_valid = 1'b0;
    chk("ovf_after5", ovf_err, 1);
    for (int k = 0; k < 4; k++) begin set_res(k); cyc(); end
    res_valid = 1'b0; cyc();
    chk("ovf_pass4", pass_cnt, 4); chk("ovf_err0", err_cnt, 0); chk("ovf_unf0", unf_err, 0);
    set_res(4); cyc(); res_valid = 1'b0; cyc();
    chk("ovf_drained_unf", unf_err, 1); chk("ovf_drained_pass", pass_cnt, 4);

    // Push and pop together while full: not an overflow
    do_reset(); do_start();
    for (int k = 0; k < 4; k++) begin set_push(k); cyc(); end
    set_push(4); set_res(0); cyc(); in_valid = 1'b0; res_valid = 1'b0;
    chk("full_pp_ovf", ovf_err, 0); chk("full_pp_pass", pass_cnt, 1);
    for (int k = 1; k < 5; k++) begin set_res(k); cyc(); end
    res_valid = 1'b0; cyc();
    chk("full_pp_pass5", pass_cnt, 5); chk("full_pp_err", err_cnt, 0); chk("full_pp_unf", unf_err, 0);

    // Underflow, and push+pop together while empty (no bypass)
    do_reset(); do_start();
    set_res(0); cyc(); res_valid = 1'b0; cyc();
    chk("unf_flag", unf_err, 1); chk("unf_pass", pass_cnt, 0);
    chk("unf_err", err_cnt, 0); chk("unf_mismatch", mismatch, 0);
    do_reset(); do_start();
    set_push(0); set_res(0); cyc(); in_valid = 1'b0; res_valid = 1'b0;
    chk("empty_pp_unf", unf_err, 1); chk("empty_pp_pass", pass_cnt, 0);
    set_res(0); cyc(); res_valid = 1'b0;
    chk("empty_pp_later_pass", pass_cnt, 1);

    // Full run: 16 vectors, latency 3, stray start mid-run must be ignored
    do_reset(); do_start();
    for (int c = 0; c < N_VEC + 3; c++) begin
      in_valid = (c < N_VEC);
      in_a = 5'(c * 3); in_b = 5'(c * 7 + 1); in_cin = c[0];
      res_valid = (c >= 3);
      {res_cout, res_sum} = ref_add(5'((c - 3) * 3), 5'((c - 3) * 7 + 1), c[0] ^ 1'b1);
      start = (c == 10);
      cyc();
    end
    in_valid = 1'b0; res_valid = 1'b0; start = 1'b0;
    chk("run_busy_drain", busy, 1); chk("run_done_early", done, 0);
    begin
      int k;
      for (k = 0; k < 20 && !done; k++) cyc();
    end
    chk("run_done", done, 1); chk("run_pass16", pass_cnt, 16); chk("run_err0", err_cnt, 0);
    chk("run_busy_done", busy, 0); chk("run_ovf", ovf_err, 0); chk("run_unf", unf_err, 0);
    do_start();
    chk("restart_busy", busy, 1); chk("restart_done", done, 0); chk("restart_pass", pass_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
